// File: rtl/fault_inject_ctrl.sv
// fault_inject_ctrl: timed XOR fault-mask sequencer aligned to pipeline-advance cycles
module fault_inject_ctrl #(
    parameter int WIDTH = 32,
    parameter int CNTW  = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             arm,
    input  logic             abort,
    input  logic             adv,
    input  logic [CNTW-1:0]  delay,
    input  logic [CNTW-1:0]  dur,
    input  logic [WIDTH-1:0] mask,
    output logic [WIDTH-1:0] flip_mask,
    output logic             busy,
    output logic             inj_active,
    output logic             done,
    output logic [7:0]       inj_count
);
    typedef enum logic [1:0] {IDLE, WAIT, INJECT, DONE} state_t;
    state_t state, state_n;
    logic [CNTW-1:0]  cnt, rem, dur_q;
    logic [WIDTH-1:0] mask_q;
    always_ff @(posedge clk) begin
        if (!reset) state <= IDLE;
        else        state <= state_n;
    end
    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = arm ? WAIT : IDLE;
            WAIT:    state_n = (cnt == '0) ? INJECT : WAIT;
            INJECT:  state_n = (adv && rem == '0) ? DONE : INJECT;
            default: state_n = IDLE;
        endcase
        if (abort) state_n = IDLE;
    end
    always_comb begin
        flip_mask  = (state == INJECT) ? mask_q : '0;
        busy       = state != IDLE;
        inj_active = state == INJECT;
        done       = state == DONE;
    end
    // Counters only step on advance cycles so the fault lines up with what the register captures
    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt       <= '0;
            rem       <= '0;
            dur_q     <= '0;
            mask_q    <= '0;
            inj_count <= '0;
        end else begin
            if (state == IDLE && arm && !abort) begin
                cnt    <= delay;
                dur_q  <= dur;
                mask_q <= mask;
            end
            if (state == WAIT && cnt != '0 && adv) cnt <= cnt - 1'b1;
            if (state == WAIT && cnt == '0) rem <= (dur_q == '0) ? '0 : dur_q - 1'b1;
            if (state == INJECT && adv && rem != '0) rem <= rem - 1'b1;
            if (state == DONE && !abort && inj_count != 8'hFF) inj_count <= inj_count + 1'b1;
        end
    end
endmodule

// File: tb/tb_fault_inject_ctrl.sv
// tb_fault_inject_ctrl: directed vector table plus hand-written corner sequences
module tb_fault_inject_ctrl;
    logic        clk = 0;
    logic        reset = 0;
    logic        arm = 0, abort = 0, adv = 1;
    logic [15:0] delay = 0, dur = 0;
    logic [31:0] mask = 0;
    logic [31:0] flip_mask;
    logic        busy, inj_active, done;
    logic [7:0]  inj_count;
    int n_cmp = 0, n_fail = 0;

    fault_inject_ctrl #(.WIDTH(32), .CNTW(16)) dut (
        .clk(clk), .reset(reset), .arm(arm), .abort(abort), .adv(adv),
        .delay(delay), .dur(dur), .mask(mask), .flip_mask(flip_mask),
        .busy(busy), .inj_active(inj_active), .done(done), .inj_count(inj_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        arm, adv;
        logic [15:0] delay, dur;
        logic [31:0] mask, e_flip;
        logic        e_busy, e_ia, e_done;
        logic [7:0]  e_cnt;
    } vec_t;
    vec_t vt[$];

    function automatic vec_t v(logic a, logic ad, logic [15:0] d, logic [15:0] du, logic [31:0] m,
                               logic [31:0] ef, logic eb, logic ei, logic ed, logic [7:0] ec);
        vec_t r;
        r.arm = a; r.adv = ad; r.delay = d; r.dur = du; r.mask = m;
        r.e_flip = ef; r.e_busy = eb; r.e_ia = ei; r.e_done = ed; r.e_cnt = ec;
        return r;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic chk_all(input string nm, input logic [31:0] ef, input logic eb, input logic ei,
                           input logic ed, input logic [7:0] ec);
        chk({nm, ".flip_mask"}, flip_mask, ef);
        chk({nm, ".busy"}, {31'b0, busy}, {31'b0, eb});
        chk({nm, ".inj_active"}, {31'b0, inj_active}, {31'b0, ei});
        chk({nm, ".done"}, {31'b0, done}, {31'b0, ed});
        chk({nm, ".inj_count"}, {24'b0, inj_count}, {24'b0, ec});
    endtask

    task automatic run_campaign();
        int k;
        arm = 1; delay = 0; dur = 0; mask = 32'h1; adv = 1;
        step();
        arm = 0;
        k = 0;
        while (!done && k < 10) begin
            step();
            k++;
        end
        if (!done) begin
            n_cmp++;
            n_fail++;
            $display("FAIL campaign_timeout: done not seen within 10 cycles");
        end
        step();
    endtask

    localparam logic [15:0] XD = 16'd7, XU = 16'd9;
    localparam logic [31:0] XM = 32'hAAAA_AAAA;

    initial begin
        step();
        step();
        chk_all("reset", 32'h0, 0, 0, 0, 8'd0);
        reset = 1;

        // delay=3 dur=2, adv always high
        vt.push_back(v(1, 1, 3, 2, 32'h4, 0, 0, 0, 0, 0));
        for (int i = 0; i < 4; i++) vt.push_back(v(0, 1, XD, XU, XM, 0, 1, 0, 0, 0));
        for (int i = 0; i < 2; i++) vt.push_back(v(0, 1, XD, XU, XM, 32'h4, 1, 1, 0, 0));
        vt.push_back(v(0, 1, XD, XU, XM, 0, 1, 0, 1, 0));
        // same again, re-armed right after done, stalls in WAIT and INJECT
        vt.push_back(v(1, 1, 3, 2, 32'h4, 0, 0, 0, 0, 1));
        vt.push_back(v(0, 1, XD, XU, XM, 0, 1, 0, 0, 1));
        vt.push_back(v(0, 0, XD, XU, XM, 0, 1, 0, 0, 1));
        for (int i = 0; i < 3; i++) vt.push_back(v(0, 1, XD, XU, XM, 0, 1, 0, 0, 1));
        vt.push_back(v(0, 0, XD, XU, XM, 32'h4, 1, 1, 0, 1));
        for (int i = 0; i < 2; i++) vt.push_back(v(0, 1, XD, XU, XM, 32'h4, 1, 1, 0, 1));
        vt.push_back(v(0, 1, XD, XU, XM, 0, 1, 0, 1, 1));
        // delay=0 dur=0 all-ones mask
        vt.push_back(v(1, 1, 0, 0, 32'hFFFF_FFFF, 0, 0, 0, 0, 2));
        vt.push_back(v(0, 1, XD, XU, XM, 0, 1, 0, 0, 2));
        vt.push_back(v(0, 1, XD, XU, XM, 32'hFFFF_FFFF, 1, 1, 0, 2));
        vt.push_back(v(0, 1, XD, XU, XM, 0, 1, 0, 1, 2));
        vt.push_back(v(0, 1, XD, XU, XM, 0, 0, 0, 0, 3));

        for (int i = 0; i < vt.size(); i++) begin
            arm = vt[i].arm; adv = vt[i].adv; delay = vt[i].delay; dur = vt[i].dur; mask = vt[i].mask;
            chk_all($sformatf("vec%0d", i), vt[i].e_flip, vt[i].e_busy, vt[i].e_ia, vt[i].e_done, vt[i].e_cnt);
            step();
        end
        arm = 0;

        // abort in first INJECT cycle; extra arm in WAIT must be ignored
        arm = 1; delay = 1; dur = 3; mask = 32'h10; adv = 1;
        step();
        arm = 1; delay = 0; dur = 0; mask = 32'h1;
        chk_all("abort_wait", 0, 1, 0, 0, 3);
        step();
        arm = 0;
        chk_all("abort_wait2", 0, 1, 0, 0, 3);
        step();
        chk_all("abort_inj", 32'h10, 1, 1, 0, 3);
        abort = 1;
        step();
        abort = 0;
        chk_all("abort_after", 0, 0, 0, 0, 3);
        for (int i = 0; i < 4; i++) begin
            step();
            chk_all("abort_quiet", 0, 0, 0, 0, 3);
        end

        // abort beats a simultaneous arm
        arm = 1; abort = 1; delay = 5; dur = 5; mask = 32'h2;
        step();
        arm = 0; abort = 0;
        chk_all("abort_vs_arm", 0, 0, 0, 0, 3);

        run_campaign();
        run_campaign();
        chk("count5", {24'b0, inj_count}, 32'd5);

        // reset mid-INJECT
        arm = 1; delay = 0; dur = 2; mask = 32'h8; adv = 1;
        step();
        arm = 0;
        step();
        chk_all("pre_reset_inj", 32'h8, 1, 1, 0, 5);
        reset = 0;
        step();
        reset = 1;
        chk_all("post_reset", 0, 0, 0, 0, 0);
        step();
        chk_all("post_reset2", 0, 0, 0, 0, 0);

        for (int i = 0; i < 256; i++) run_campaign();
        chk("count_sat", {24'b0, inj_count}, 32'd255);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/fault_inject_ctrl.md
# fault_inject_ctrl

Sequencer for fault-injection campaigns on the pipelined RISC-V core. It produces a timed XOR mask that the datapath applies to a chosen pipeline register's `d` input. Software or the bench arms it with a delay, a duration and a bit mask. The block counts pipeline-advance cycles, drives the mask for the programmed number of advance cycles, then reports completion. It sits beside the pipeline registers and keeps injections aligned to stalls.

## Interface
Parameters:
- `WIDTH`, 32, width of the target pipeline register and the fault mask
- `CNTW`, 16, width of the delay and duration counters

Ports:
- `clk`  in  1  rising-edge clock
- `reset`  in  1  synchronous, active-low reset
- `arm`  in  1  start request; sampled only in IDLE
- `abort`  in  1  cancel; honoured in every state
- `adv`  in  1  target register enable (pipeline advancing this cycle)
- `delay`  in  CNTW  advance cycles to wait before injecting; latched on arm
- `dur`  in  CNTW  advance cycles to hold the fault; latched on arm; 0 is treated as 1
- `mask`  in  WIDTH  bits to flip; latched on arm
- `flip_mask`  out  WIDTH  XOR mask to the target register `d`; 0 when not injecting
- `busy`  out  1  high in any state other than IDLE
- `inj_active`  out  1  high in INJECT
- `done`  out  1  one-cycle pulse on normal completion
- `inj_count`  out  8  saturating count of completed injections

## Operation
- States:
  - IDLE: waits for `arm`.
  - WAIT: holds off until the delay expires.
  - INJECT: drives the latched mask.
  - DONE: reports completion.
- All outputs are decoded from registers only. There is no combinational path from any input to any output.
- IDLE:
  - `arm`=1 and `abort`=0: latch `delay`→`cnt`, `dur`→`dur_q`, `mask`→`mask_q`, then go to WAIT.
  - `arm` is ignored in every other state.
- WAIT:
  - `cnt`==0: go to INJECT and load `rem`=`dur_q`-1. If `dur_q`=0, load `rem`=0. This transition does not depend on `adv`.
  - `cnt`!=0 and `adv`=1: `cnt` decrements by 1.
  - `cnt`!=0 and `adv`=0: `cnt` holds.
- INJECT:
  - `flip_mask`=`mask_q` and `inj_active`=1.
  - `adv`=1 and `rem`==0: go to DONE.
  - `adv`=1 and `rem`!=0: `rem` decrements by 1.
  - `adv`=0: `rem` holds, so the fault persists across stalls until the register actually captures it.
- DONE:
  - `done`=1 for exactly one cycle.
  - `inj_count` increments, saturating at 255.
  - Next state is IDLE unconditionally.
- `abort`:
  - In any state, the next state is IDLE.
  - `flip_mask` is 0 from the next cycle.
  - No `done` pulse and no `inj_count` increment.
  - `abort` wins over a simultaneous `arm`.
- `mask`=0 is legal: the block runs the full sequence and drives an all-zero `flip_mask`.
- Counter arithmetic is unsigned, CNTW bits. Counters never wrap because decrement is gated on !=0.

## Timing
- Reset (`reset`=0 at a rising edge): IDLE, `flip_mask`=0, `busy`=0, `inj_active`=0, `done`=0, `inj_count`=0, internal counters 0. Reset mid-INJECT removes the mask on the next cycle.
- With `adv` held at 1 and `arm` sampled at cycle 0:
  - WAIT occupies cycles 1..delay+1.
  - INJECT occupies cycles delay+2..delay+1+max(dur,1).
  - `done` follows in the next cycle.
  - `busy` is high from cycle 1 through the `done` cycle.
- Each `adv`=0 cycle in WAIT or INJECT extends that state by one cycle.
- Back-to-back campaigns: `arm` in the cycle after `done` (state is IDLE) is accepted. Minimum re-arm spacing is delay+max(dur,1)+3 cycles.

## Test plan
- Reset, then `arm` at cycle 0 with `delay`=3, `dur`=2, `mask`=32'h0000_0004, `adv`=1 → `flip_mask`=32'h4 in cycles 5–6 only, `done` in cycle 7, `inj_count`=1, `busy` high in cycles 1–7.
- Same stimulus with `adv`=0 in cycles 2 and 6 → injection in cycles 6–8, `done` in cycle 9.
- `delay`=0, `dur`=0, `mask`=32'hFFFF_FFFF → `flip_mask` all ones in cycle 2 only, `done` in cycle 3.
- `abort` during the first INJECT cycle → `flip_mask`=0 and state IDLE next cycle, no `done`, `inj_count` unchanged. A second `arm` pulse during WAIT is ignored, and the latched values are unchanged.
- `reset` asserted for one cycle mid-INJECT with `inj_count`=5 → next cycle all outputs 0 and `inj_count`=0. Then 256 completed campaigns → `inj_count` saturates at 255.
